// File: rtl/lfsr_loader.sv
// Serial loader for the downstream LFSR.
// Captures a parallel seed and tap mask on start. Shifts the tap mask out first, then the
// seed, on the LFSR's load_tap_reg / load_s_reg / reg_in interface.
// Sending taps first keeps feedback shifting during the tap phase from disturbing the seed.
module lfsr_loader #(
  parameter int unsigned n         = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         seed_only,
  input  logic [n-1:0] seed,
  input  logic [n-1:0] taps,
  output logic         busy,
  output logic         done,
  output logic         zero_seed,
  output logic         load_tap_reg,
  output logic         load_s_reg,
  output logic         reg_in
);

  localparam int unsigned CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(n - 1);

  typedef enum logic [1:0] {
    StIdle,
    StTap,
    StSeed,
    StDone
  } state_e;

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [n-1:0]  r_seed_cap;
  logic [n-1:0]  r_taps_cap;
  logic          r_busy;
  logic          r_done;
  logic          r_zero_seed;
  logic          r_load_tap;
  logic          r_load_s;
  logic          r_reg_in;

  logic [CW-1:0] w_cnt_inc;

  // Bit i of the serial stream for word v under the configured ordering.
  function automatic logic sel_bit(input logic [n-1:0] v, input logic [CW-1:0] i);
    logic [CW-1:0] idx;
    idx = MSB_FIRST ? (LastCnt - i) : i;
    return v[idx];
  endfunction

  // Next bit index within the current phase.
  always_comb begin
    w_cnt_inc = r_cnt + CW'(1);
  end

  // Sequencer: outputs are registered one step ahead so they line up with the counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_seed_cap  <= '0;
      r_taps_cap  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_zero_seed <= 1'b0;
      r_load_tap  <= 1'b0;
      r_load_s    <= 1'b0;
      r_reg_in    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done      <= 1'b0;
          r_zero_seed <= 1'b0;
          r_cnt       <= '0;
          if (start) begin
            r_seed_cap <= seed;
            r_taps_cap <= taps;
            r_busy     <= 1'b1;
            if (seed_only) begin
              r_state    <= StSeed;
              r_load_tap <= 1'b0;
              r_load_s   <= 1'b1;
              r_reg_in   <= sel_bit(seed, '0);
            end else begin
              r_state    <= StTap;
              r_load_tap <= 1'b1;
              r_load_s   <= 1'b0;
              r_reg_in   <= sel_bit(taps, '0);
            end
          end else begin
            r_busy     <= 1'b0;
            r_load_tap <= 1'b0;
            r_load_s   <= 1'b0;
            r_reg_in   <= 1'b0;
          end
        end
        StTap: begin
          if (r_cnt == LastCnt) begin
            r_state    <= StSeed;
            r_cnt      <= '0;
            r_load_tap <= 1'b0;
            r_load_s   <= 1'b1;
            r_reg_in   <= sel_bit(r_seed_cap, '0);
          end else begin
            r_cnt    <= w_cnt_inc;
            r_reg_in <= sel_bit(r_taps_cap, w_cnt_inc);
          end
        end
        StSeed: begin
          if (r_cnt == LastCnt) begin
            r_state     <= StDone;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_load_tap  <= 1'b0;
            r_load_s    <= 1'b0;
            r_reg_in    <= 1'b0;
            r_done      <= 1'b1;
            r_zero_seed <= (r_seed_cap == '0);
          end else begin
            r_cnt    <= w_cnt_inc;
            r_reg_in <= sel_bit(r_seed_cap, w_cnt_inc);
          end
        end
        StDone: begin
          // start is ignored here; a held start is taken on the following IDLE cycle
          r_state     <= StIdle;
          r_done      <= 1'b0;
          r_zero_seed <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign zero_seed    = r_zero_seed;
  assign load_tap_reg = r_load_tap;
  assign load_s_reg   = r_load_s;
  assign reg_in       = r_reg_in;

endmodule

// File: tb/tb_lfsr_loader.sv
// Bench for lfsr_loader: per-cycle expected output vectors are queued when a sequence is
// started and popped one per clock as the DUT produces them.
module tb_lfsr_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic       seed_only;
  logic [7:0] seed;
  logic [7:0] taps;

  logic busy0, done0, zero0, ltap0, ls0, rin0;
  logic busy1, done1, zero1, ltap1, ls1, rin1;

  // {busy, done, zero_seed, load_tap_reg, load_s_reg, reg_in}
  logic [5:0] obs0;
  logic [5:0] obs1;
  logic [5:0] exp_q[$];
  logic [5:0] e;

  logic [7:0] rx_tap;
  logic [7:0] rx_seed;

  int checks = 0;
  int errors = 0;
  int cyc;

  lfsr_loader #(.n(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .start(start), .seed_only(seed_only), .seed(seed),
    .taps(taps), .busy(busy0), .done(done0), .zero_seed(zero0), .load_tap_reg(ltap0),
    .load_s_reg(ls0), .reg_in(rin0)
  );

  lfsr_loader #(.n(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .start(start), .seed_only(seed_only), .seed(seed),
    .taps(taps), .busy(busy1), .done(done1), .zero_seed(zero1), .load_tap_reg(ltap1),
    .load_s_reg(ls1), .reg_in(rin1)
  );

  assign obs0 = {busy0, done0, zero0, ltap0, ls0, rin0};
  assign obs1 = {busy1, done1, zero1, ltap1, ls1, rin1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiving LFSR registers, shifting in at the MSB-first DUT's load strobes.
  always @(posedge clk) begin
    if (ltap0) rx_tap <= {rx_tap[6:0], rin0};
    if (ls0) rx_seed <= {rx_seed[6:0], rin0};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [7:0] v, input int i, input bit msb);
    return msb ? v[7-i] : v[i];
  endfunction

  // Expected outputs from cycle k+1 through one IDLE cycle after DONE.
  task automatic push_seq(input logic [7:0] s, input logic [7:0] t, input bit so,
                          input bit msb);
    if (!so) begin
      for (int i = 0; i < 8; i++) exp_q.push_back({5'b10010, exp_bit(t, i, msb)});
    end
    for (int i = 0; i < 8; i++) exp_q.push_back({5'b10001, exp_bit(s, i, msb)});
    exp_q.push_back({2'b01, (s == 8'h00), 3'b000});
    exp_q.push_back(6'b000000);
  endtask

  task automatic launch(input logic [7:0] s, input logic [7:0] t, input bit so);
    seed      = s;
    taps      = t;
    seed_only = so;
    start     = 1'b1;
    cyc       = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    launch(8'hFF, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs0 !== 6'b0 || obs1 !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got %b/%b expected 000000", i, obs0, obs1);
      end
    end
    start = 1'b0;
    reset = 1'b1;
    step();
    checks++;
    if (obs0 !== 6'b0) begin
      errors++;
      $display("FAIL reset_release: got %b expected 000000", obs0);
    end
  endtask

  task automatic test_full(input logic [7:0] s, input logic [7:0] t, input string name);
    push_seq(s, t, 1'b0, 1'b1);
    launch(s, t, 1'b0);
    while (exp_q.size() > 0) begin
      step();
      cyc++;
      if (cyc == 1) start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs0 !== e) begin
        errors++;
        $display("FAIL %s cyc%0d: got %b expected %b", name, cyc, obs0, e);
      end
    end
    checks++;
    if (rx_tap !== t || rx_seed !== s) begin
      errors++;
      $display("FAIL %s_rx: got tap=%h seed=%h expected tap=%h seed=%h",
               name, rx_tap, rx_seed, t, s);
    end
  endtask

  task automatic test_seed_only(input logic [7:0] s, input string name);
    push_seq(s, 8'h00, 1'b1, 1'b1);
    launch(s, 8'hFF, 1'b1);
    while (exp_q.size() > 0) begin
      step();
      cyc++;
      if (cyc == 1) start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs0 !== e) begin
        errors++;
        $display("FAIL %s cyc%0d: got %b expected %b", name, cyc, obs0, e);
      end
    end
  endtask

  task automatic test_ignore_start();
    push_seq(8'hA5, 8'hB8, 1'b0, 1'b1);
    launch(8'hA5, 8'hB8, 1'b0);
    while (exp_q.size() > 0) begin
      step();
      cyc++;
      e = exp_q.pop_front();
      checks++;
      if (obs0 !== e) begin
        errors++;
        $display("FAIL ignore_start cyc%0d: got %b expected %b", cyc, obs0, e);
      end
      if (cyc == 5 || cyc == 17) begin
        start     = 1'b1;
        seed      = 8'h5A;
        taps      = 8'h47;
        seed_only = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    push_seq(8'hA5, 8'hB8, 1'b0, 1'b1);
    launch(8'hA5, 8'hB8, 1'b0);
    while (cyc < 10) begin
      step();
      cyc++;
      if (cyc == 1) start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs0 !== e) begin
        errors++;
        $display("FAIL reset_mid cyc%0d: got %b expected %b", cyc, obs0, e);
      end
    end
    exp_q.delete();
    reset = 1'b0;
    step();
    checks++;
    if (obs0 !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid cyc11: got %b expected 000000", obs0);
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (obs0 !== 6'b0) begin
        errors++;
        $display("FAIL reset_mid_idle cyc%0d: got %b expected 000000", 12 + i, obs0);
      end
    end
    test_full(8'hA5, 8'hB8, "restart_after_reset");
  endtask

  task automatic test_lsb_first();
    push_seq(8'h01, 8'h00, 1'b1, 1'b0);
    launch(8'h01, 8'h80, 1'b1);
    while (exp_q.size() > 0) begin
      step();
      cyc++;
      if (cyc == 1) start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        errors++;
        $display("FAIL lsb_first cyc%0d: got %b expected %b", cyc, obs1, e);
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    seed_only = 1'b0;
    seed      = 8'h00;
    taps      = 8'h00;
    rx_tap    = 8'h00;
    rx_seed   = 8'h00;
    test_reset();
    test_full(8'hA5, 8'hB8, "full_a5_b8");
    test_seed_only(8'h3C, "seed_only_3c");
    test_full(8'h00, 8'h8E, "zero_seed_full");
    test_seed_only(8'h01, "nonzero_seed_01");
    test_ignore_start();
    test_reset_mid();
    test_lsb_first();
    test_full(8'h6D, 8'h1F, "full_6d_1f");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
